// File: rtl/ct_lsu_spsram_access_ctrl.sv
// Requester-side controller for the single-port SRAM macro: clears the array after
// reset, then turns a valid/ready word-access stream into registered macro pins.
module ct_lsu_spsram_access_ctrl #(
    parameter int                    ADDR_WIDTH = 13,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    INIT_EN    = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic                      req_wr,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_be,
    output logic                      rsp_vld,
    input  logic                      rsp_rdy,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      init_done,
    output logic [ADDR_WIDTH-1:0]     sram_a,
    output logic                      sram_cen,
    output logic                      sram_gwen,
    output logic [DATA_WIDTH-1:0]     sram_wen,
    output logic [DATA_WIDTH-1:0]     sram_d,
    input  logic [DATA_WIDTH-1:0]     sram_q
);

    localparam int                    BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic                    init_done_q, init_done_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    rd_issue_q, rd_issue_d;
    logic                    rd_cap_q, rd_cap_d;
    logic [ADDR_WIDTH-1:0]   sram_a_q, sram_a_d;
    logic                    sram_cen_q, sram_cen_d;
    logic                    sram_gwen_q, sram_gwen_d;
    logic [DATA_WIDTH-1:0]   sram_wen_q, sram_wen_d;
    logic [DATA_WIDTH-1:0]   sram_d_q, sram_d_d;
    logic [DATA_WIDTH-1:0]   fifo_q [2];
    logic [DATA_WIDTH-1:0]   fifo_d [2];
    logic                    wptr_q, wptr_d;
    logic                    rptr_q, rptr_d;
    logic [1:0]              fcnt_q, fcnt_d;
    logic                    req_acc;
    logic                    rd_acc;
    logic                    rsp_pop;

    function automatic logic [DATA_WIDTH-1:0] be_to_mask(input logic [BE_WIDTH-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '1;
        for (int b = 0; b < BE_WIDTH; b++) begin
            m[8*b +: 8] = {8{~be[b]}};
        end
        return m;
    endfunction

    // cnt covers reads in the macro pipeline plus FIFO occupancy, so the FIFO never overflows
    assign req_rdy   = init_done_q & (cnt_q < 2'd2);
    assign req_acc   = req_vld & req_rdy;
    assign rd_acc    = req_acc & ~req_wr;
    assign rsp_vld   = (fcnt_q != 2'd0);
    assign rsp_pop   = rsp_vld & rsp_rdy;
    assign rsp_rdata = fifo_q[rptr_q];

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        init_done_d = init_done_q;
        sram_a_d    = sram_a_q;
        sram_d_d    = sram_d_q;
        sram_cen_d  = 1'b1;
        sram_gwen_d = 1'b1;
        sram_wen_d  = '1;
        rd_issue_d  = 1'b0;
        rd_cap_d    = rd_issue_q;

        case (state_q)
            ST_INIT: begin
                if (INIT_EN != 0) begin
                    sram_cen_d  = 1'b0;
                    sram_gwen_d = 1'b0;
                    sram_wen_d  = '0;
                    sram_a_d    = idx_q;
                    sram_d_d    = INIT_VALUE;
                    idx_d       = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            default: begin
                init_done_d = 1'b1;
                if (req_acc) begin
                    if (req_wr) begin
                        // all-zero byte enables complete without touching the macro
                        if (|req_be) begin
                            sram_cen_d  = 1'b0;
                            sram_gwen_d = 1'b0;
                            sram_wen_d  = be_to_mask(req_be);
                            sram_a_d    = req_addr;
                            sram_d_d    = req_wdata;
                        end
                    end else begin
                        sram_cen_d = 1'b0;
                        sram_a_d   = req_addr;
                        rd_issue_d = 1'b1;
                    end
                end
            end
        endcase

        cnt_d     = cnt_q + 2'(rd_acc) - 2'(rsp_pop);
        fifo_d[0] = fifo_q[0];
        fifo_d[1] = fifo_q[1];
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        if (rd_cap_q) begin
            fifo_d[wptr_q] = sram_q;
            wptr_d         = ~wptr_q;
        end
        if (rsp_pop) begin
            rptr_d = ~rptr_q;
        end
        fcnt_d = fcnt_q + 2'(rd_cap_q) - 2'(rsp_pop);
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q     <= ST_INIT;
            idx_q       <= '0;
            init_done_q <= 1'b0;
            cnt_q       <= '0;
            rd_issue_q  <= 1'b0;
            rd_cap_q    <= 1'b0;
            sram_a_q    <= '0;
            sram_cen_q  <= 1'b1;
            sram_gwen_q <= 1'b1;
            sram_wen_q  <= '1;
            sram_d_q    <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
            cnt_q       <= cnt_d;
            rd_issue_q  <= rd_issue_d;
            rd_cap_q    <= rd_cap_d;
            sram_a_q    <= sram_a_d;
            sram_cen_q  <= sram_cen_d;
            sram_gwen_q <= sram_gwen_d;
            sram_wen_q  <= sram_wen_d;
            sram_d_q    <= sram_d_d;
            fifo_q[0]   <= fifo_d[0];
            fifo_q[1]   <= fifo_d[1];
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fcnt_q      <= fcnt_d;
        end
    end

    assign init_done = init_done_q;
    assign sram_a    = sram_a_q;
    assign sram_cen  = sram_cen_q;
    assign sram_gwen = sram_gwen_q;
    assign sram_wen  = sram_wen_q;
    assign sram_d    = sram_d_q;

endmodule

// File: tb/tb_ct_lsu_spsram_access_ctrl.sv
// Bench for ct_lsu_spsram_access_ctrl: behavioural 8192x32 macro, directed stimulus,
// read responses checked in order against a scoreboard queue.
module tb_ct_lsu_spsram_access_ctrl;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld, req_rdy, req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [BW-1:0] req_be;
    logic          rsp_vld, rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d;
    logic [DW-1:0] sram_q;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    ct_lsu_spsram_access_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1), .INIT_VALUE(32'h0)
    ) dut (
        .forever_cpuclk(clk),  .cpurst(rst),
        .req_vld(req_vld),     .req_rdy(req_rdy),     .req_wr(req_wr),
        .req_addr(req_addr),   .req_wdata(req_wdata), .req_be(req_be),
        .rsp_vld(rsp_vld),     .rsp_rdy(rsp_rdy),     .rsp_rdata(rsp_rdata),
        .init_done(init_done), .sram_a(sram_a),       .sram_cen(sram_cen),
        .sram_gwen(sram_gwen), .sram_wen(sram_wen),   .sram_d(sram_d),
        .sram_q(sram_q)
    );

    // Macro model: bit-masked write, read data on Q the cycle after the access
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= mem[sram_a];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, input logic [DW-1:0] exp, input bit track);
        int n;
        n = 0;
        req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
        while (!req_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_accept", 64'(req_rdy), 64'(1));
        if (req_rdy && !wr && track) exp_q.push_back(exp);
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    initial begin : monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (rsp_vld && rsp_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got %0h with no expected entry", rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", 64'(rsp_rdata), 64'(e));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int bad;
        int n;
        rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_rdy = 1'b1;
        repeat (3) @(negedge clk);

        // T1: reset values, then full-array clear
        check("rst_req_rdy",   64'(req_rdy),   64'(0));
        check("rst_rsp_vld",   64'(rsp_vld),   64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_cen_gwen",  64'({sram_cen, sram_gwen}), 64'(2'b11));
        check("rst_wen",       64'(sram_wen),  64'(32'hFFFF_FFFF));
        check("rst_a_d",       64'({sram_a, sram_d}), 64'(0));
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge clk);
            if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== 32'h0 ||
                sram_a !== i[AW-1:0] || sram_d !== 32'h0 || init_done !== 1'b0) bad++;
        end
        check("init_sweep_bad_cycles", 64'(bad), 64'(0));
        @(negedge clk);
        check("init_done_after", 64'(init_done), 64'(1));
        check("rdy_after_init",  64'(req_rdy),   64'(1));
        check("idle_cen",        64'(sram_cen),  64'(1));

        // T2: full write then read with latency check
        send(1'b1, 13'h0005, 32'hDEAD_BEEF, 4'hF, '0, 1'b0);
        check("t2_wr_ctl",  64'({sram_cen, sram_gwen}), 64'(2'b00));
        check("t2_wr_a",    64'(sram_a),   64'(13'h0005));
        check("t2_wr_d",    64'(sram_d),   64'(32'hDEAD_BEEF));
        check("t2_wr_wen",  64'(sram_wen), 64'(32'h0));
        send(1'b0, 13'h0005, '0, 4'h0, 32'hDEAD_BEEF, 1'b1);
        check("t2_rd_ctl",  64'({sram_cen, sram_gwen}), 64'(2'b01));
        check("t2_rd_wen",  64'(sram_wen), 64'(32'hFFFF_FFFF));
        check("t2_rd_a",    64'(sram_a),   64'(13'h0005));
        check("t2_vld_n1",  64'(rsp_vld),  64'(0));
        @(negedge clk);
        check("t2_vld_n2",  64'(rsp_vld),  64'(0));
        @(negedge clk);
        check("t2_vld_n3",  64'(rsp_vld),  64'(1));

        // T3: partial byte enables at the top address
        send(1'b1, 13'h1FFF, 32'h1122_3344, 4'b0101, '0, 1'b0);
        check("t3_wen",     64'(sram_wen), 64'(32'hFF00_FF00));
        check("t3_a",       64'(sram_a),   64'(13'h1FFF));
        send(1'b0, 13'h1FFF, '0, 4'h0, 32'h0022_0044, 1'b1);
        repeat (4) @(negedge clk);

        // T4: backpressure with three back-to-back reads
        send(1'b1, 13'h0010, 32'hAAAA_0001, 4'hF, '0, 1'b0);
        send(1'b1, 13'h0011, 32'hBBBB_0002, 4'hF, '0, 1'b0);
        send(1'b1, 13'h0012, 32'hCCCC_0003, 4'hF, '0, 1'b0);
        rsp_rdy = 1'b0;
        send(1'b0, 13'h0010, '0, 4'h0, 32'hAAAA_0001, 1'b1);
        send(1'b0, 13'h0011, '0, 4'h0, 32'hBBBB_0002, 1'b1);
        check("t4_rdy_drop", 64'(req_rdy), 64'(0));
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 13'h0012;
        repeat (4) @(negedge clk);
        check("t4_hold_vld",   64'(rsp_vld),   64'(1));
        check("t4_hold_rdata", 64'(rsp_rdata), 64'(32'hAAAA_0001));
        check("t4_hold_rdy",   64'(req_rdy),   64'(0));
        @(negedge clk);
        check("t4_hold_rdata2", 64'(rsp_rdata), 64'(32'hAAAA_0001));
        rsp_rdy = 1'b1;
        n = 0;
        while (!req_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_third_rdy", 64'(req_rdy), 64'(1));
        if (req_rdy) exp_q.push_back(32'hCCCC_0003);
        @(negedge clk);
        req_vld = 1'b0;
        repeat (6) @(negedge clk);

        // T5: zero byte enables
        send(1'b1, 13'h0020, 32'h1234_5678, 4'h0, '0, 1'b0);
        check("t5_no_access", 64'(sram_cen), 64'(1));
        send(1'b0, 13'h0020, '0, 4'h0, 32'h0, 1'b1);
        repeat (5) @(negedge clk);

        // T6: reset with two reads in flight
        send(1'b0, 13'h0010, '0, 4'h0, '0, 1'b0);
        send(1'b0, 13'h0011, '0, 4'h0, '0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rsp_vld",   64'(rsp_vld),   64'(0));
        check("t6_cen",       64'(sram_cen),  64'(1));
        check("t6_req_rdy",   64'(req_rdy),   64'(0));
        check("t6_init_done", 64'(init_done), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_init_a0", 64'({sram_cen, sram_gwen, sram_a}), 64'(15'h0000));
        @(negedge clk);
        check("t6_init_a1", 64'({sram_cen, sram_gwen, sram_a}), 64'(15'h0001));
        n = 0;
        while (!init_done && n < 9000) begin
            @(negedge clk);
            n++;
        end
        check("t6_init_done_again", 64'(init_done), 64'(1));
        send(1'b0, 13'h0010, '0, 4'h0, 32'h0, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("sb_drained", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
